uart_hd_phy: RTL and testbench

- Single-wire, half-duplex UART PHY for the UPDI link, replacing the separate tx/rx wire pair with one open-drain line.
- Adds a runtime baud divisor, break generation and detection, a post-transmit guard time, and echo suppression.
- Sits between the UPDI protocol engine and the pad: byte handshake on one side, pull-low / line-sense on the other.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_hd_phy_if.sv | 26 ++
 rtl/uart_baud_gen.sv | 35 +++
 rtl/uart_hd_phy.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_hd_phy.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the single-wire half-duplex UART PHY.
package uart_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TX_START,
        ST_TX_DATA,
        ST_TX_PARITY,
        ST_TX_STOP,
        ST_TX_GUARD,
        ST_TX_BREAK,
        ST_RX_START,
        ST_RX_DATA,
        ST_RX_PARITY,
        ST_RX_STOP,
        ST_RX_WAIT_HIGH
    } uart_hd_state;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    localparam int unsigned MIN_DIV = 4;

    // Wide enough for the longest per-state bit count (break length).
    localparam int CNT_W = 5;

endpackage

// File: rtl/uart_hd_phy_if.sv
// Byte-side handshake between the UPDI protocol engine (master) and the PHY (slave).
interface uart_hd_phy_if #(
    parameter int DATA_BITS = 8,
    parameter int DIV_WIDTH = 16
);
    logic [DIV_WIDTH-1:0] baud_div;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_start;
    logic                 send_break;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_break;

    modport master (
        output baud_div, tx_data, tx_start, send_break,
        input  tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_break
    );

    modport slave (
        input  baud_div, tx_data, tx_start, send_break,
        output tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_break
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Loadable bit-time down-counter; one tick per bit, optional half-period first load.
module uart_baud_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DIV_WIDTH-1:0] i_div,
    input  logic                 i_load,
    input  logic                 i_half,
    input  logic                 i_en,
    output logic                 o_tick
);
    import uart_pkg::*;

    logic [DIV_WIDTH-1:0] r_div;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] w_div_eff;

    assign w_div_eff = (i_div < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : i_div;
    assign o_tick    = i_en && !i_load && (r_cnt == '0);

    // Divisor is captured only at load so a frame in flight keeps its bit time.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div <= DIV_WIDTH'(MIN_DIV);
            r_cnt <= '0;
        end else if (i_load) begin
            r_div <= w_div_eff;
            r_cnt <= i_half ? ((w_div_eff >> 1) - DIV_WIDTH'(1)) : (w_div_eff - DIV_WIDTH'(1));
        end else if (i_en) begin
            r_cnt <= (r_cnt == '0) ? (r_div - DIV_WIDTH'(1)) : (r_cnt - DIV_WIDTH'(1));
        end
    end

endmodule

// File: rtl/uart_hd_phy.sv
// Single-wire half-duplex UART PHY with break, guard time and echo suppression.
//   state        | meaning
//   IDLE         | line released, accepts tx/break, watches for falling edge
//   TX_START     | driving start bit low
//   TX_DATA      | driving data bits, LSB first
//   TX_PARITY    | driving parity bit
//   TX_STOP      | stop bits, line released
//   TX_GUARD     | post-transmit idle hold
//   TX_BREAK     | driving break low
//   RX_START     | waiting for mid start bit, rejects false starts
//   RX_DATA      | sampling data bits at mid-bit
//   RX_PARITY    | sampling parity bit
//   RX_STOP      | sampling first stop bit, reports result
//   RX_WAIT_HIGH | after a low stop bit, waits for the line to return high
module uart_hd_phy #(
    parameter int    DATA_BITS  = 8,
    parameter string PARITY_BIT = "even",
    parameter int    STOP_BITS  = 2,
    parameter int    DIV_WIDTH  = 16,
    parameter int    GUARD_BITS = 2,
    parameter int    BREAK_BITS = 12
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    uart_hd_phy_if.slave   bus,
    input  logic           i_line,
    output logic           o_line_pull_low
);
    import uart_pkg::*;

    localparam int   PAR_MODE = (PARITY_BIT == "none") ? PAR_NONE :
                                (PARITY_BIT == "odd")  ? PAR_ODD  : PAR_EVEN;
    localparam logic HAS_PAR  = (PAR_MODE != PAR_NONE);
    localparam logic ODD      = (PAR_MODE == PAR_ODD);

    uart_hd_state         r_state, w_state_next;
    logic [1:0]           r_sync;
    logic                 r_line_d;
    logic                 w_line;
    logic                 w_fall;
    logic [CNT_W-1:0]     r_bit, w_bit_next;
    logic [DATA_BITS-1:0] r_shift, w_shift_next;
    logic                 r_par, w_par_next;
    logic                 w_load, w_half, w_tick, w_bg_en;
    logic                 r_pull_low, w_pull_next;
    logic [DATA_BITS-1:0] r_rx_data, w_rx_data_next;
    logic                 r_rx_valid, w_rx_valid;
    logic                 r_rx_perr, w_rx_perr;
    logic                 r_rx_ferr, w_rx_ferr;
    logic                 r_rx_break, w_rx_break;
    logic                 w_par_mismatch;
    logic                 w_all_zero;

    assign w_line         = r_sync[1];
    assign w_fall         = r_line_d && !w_line;
    assign w_bg_en        = (r_state != ST_IDLE) && (r_state != ST_RX_WAIT_HIGH);
    assign w_par_mismatch = HAS_PAR && (r_par != ((^r_shift) ^ ODD));
    assign w_all_zero     = (r_shift == '0) && !(HAS_PAR && r_par);

    uart_baud_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_gen (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_div   (bus.baud_div),
        .i_load  (w_load),
        .i_half  (w_half),
        .i_en    (w_bg_en),
        .o_tick  (w_tick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_sync     <= 2'b11;
            r_line_d   <= 1'b1;
            r_bit      <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_pull_low <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_perr  <= 1'b0;
            r_rx_ferr  <= 1'b0;
            r_rx_break <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_sync     <= {r_sync[0], i_line};
            r_line_d   <= w_line;
            r_bit      <= w_bit_next;
            r_shift    <= w_shift_next;
            r_par      <= w_par_next;
            r_pull_low <= w_pull_next;
            r_rx_data  <= w_rx_data_next;
            r_rx_valid <= w_rx_valid;
            r_rx_perr  <= w_rx_perr;
            r_rx_ferr  <= w_rx_ferr;
            r_rx_break <= w_rx_break;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_load         = 1'b0;
        w_half         = 1'b0;
        w_shift_next   = r_shift;
        w_par_next     = r_par;
        w_rx_data_next = r_rx_data;
        w_rx_valid     = 1'b0;
        w_rx_perr      = 1'b0;
        w_rx_ferr      = 1'b0;
        w_rx_break     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A transmit request wins over a simultaneous falling edge.
                if (bus.send_break) begin
                    w_state_next = ST_TX_BREAK;
                    w_load       = 1'b1;
                end else if (bus.tx_start) begin
                    w_state_next = ST_TX_START;
                    w_load       = 1'b1;
                    w_shift_next = bus.tx_data;
                    w_par_next   = (^bus.tx_data) ^ ODD;
                end else if (w_fall) begin
                    w_state_next = ST_RX_START;
                    w_load       = 1'b1;
                    w_half       = 1'b1;
                end
            end
            ST_TX_START: begin
                if (w_tick) w_state_next = ST_TX_DATA;
            end
            ST_TX_DATA: begin
                if (w_tick) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit == CNT_W'(DATA_BITS - 1))
                        w_state_next = HAS_PAR ? ST_TX_PARITY : ST_TX_STOP;
                end
            end
            ST_TX_PARITY: begin
                if (w_tick) w_state_next = ST_TX_STOP;
            end
            ST_TX_STOP: begin
                if (w_tick && (r_bit == CNT_W'(STOP_BITS - 1))) w_state_next = ST_TX_GUARD;
            end
            ST_TX_GUARD: begin
                if (w_tick && (r_bit == CNT_W'(GUARD_BITS - 1))) w_state_next = ST_IDLE;
            end
            ST_TX_BREAK: begin
                if (w_tick && (r_bit == CNT_W'(BREAK_BITS - 1))) w_state_next = ST_TX_GUARD;
            end
            ST_RX_START: begin
                if (w_tick) w_state_next = w_line ? ST_IDLE : ST_RX_DATA;
            end
            ST_RX_DATA: begin
                if (w_tick) begin
                    w_shift_next = {w_line, r_shift[DATA_BITS-1:1]};
                    if (r_bit == CNT_W'(DATA_BITS - 1))
                        w_state_next = HAS_PAR ? ST_RX_PARITY : ST_RX_STOP;
                end
            end
            ST_RX_PARITY: begin
                if (w_tick) begin
                    w_par_next   = w_line;
                    w_state_next = ST_RX_STOP;
                end
            end
            ST_RX_STOP: begin
                if (w_tick) begin
                    if (w_line) begin
                        w_rx_valid     = 1'b1;
                        w_rx_data_next = r_shift;
                        w_rx_perr      = w_par_mismatch;
                        w_state_next   = ST_IDLE;
                    end else if (w_all_zero) begin
                        w_rx_break     = 1'b1;
                        w_state_next   = ST_RX_WAIT_HIGH;
                    end else begin
                        w_rx_valid     = 1'b1;
                        w_rx_data_next = r_shift;
                        w_rx_perr      = w_par_mismatch;
                        w_rx_ferr      = 1'b1;
                        w_state_next   = ST_RX_WAIT_HIGH;
                    end
                end
            end
            ST_RX_WAIT_HIGH: begin
                if (w_line) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_bit_next = r_bit;
        if (w_state_next != r_state) w_bit_next = '0;
        else if (w_tick)             w_bit_next = r_bit + CNT_W'(1);
    end

    // Pad drive is registered from the next state so it tracks state changes exactly.
    always_comb begin
        w_pull_next = 1'b0;
        case (w_state_next)
            ST_TX_START:  w_pull_next = 1'b1;
            ST_TX_BREAK:  w_pull_next = 1'b1;
            ST_TX_DATA:   w_pull_next = ~w_shift_next[0];
            ST_TX_PARITY: w_pull_next = ~w_par_next;
            default:      w_pull_next = 1'b0;
        endcase
    end

    assign o_line_pull_low   = r_pull_low;
    assign bus.tx_ready      = (r_state == ST_IDLE);
    assign bus.rx_data       = r_rx_data;
    assign bus.rx_valid      = r_rx_valid;
    assign bus.rx_parity_err = r_rx_perr;
    assign bus.rx_frame_err  = r_rx_ferr;
    assign bus.rx_break      = r_rx_break;

endmodule

// File: tb/tb_uart_hd_phy.sv
// Directed bench for uart_hd_phy: 8E2, baud_div=8, open-drain loopback on the pad.
module tb_uart_hd_phy;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ext_line = 1'b1;
    logic line_i;
    logic pull_low;

    int n_checks = 0;
    int n_err = 0;
    int valid_cnt = 0;
    int break_cnt = 0;
    int flag_viol = 0;
    logic [7:0] cap_data = 8'h00;
    logic cap_perr = 1'b0;
    logic cap_ferr = 1'b0;

    uart_hd_phy_if #(.DATA_BITS(8), .DIV_WIDTH(16)) u_if ();

    assign line_i = ext_line & ~pull_low;

    uart_hd_phy #(
        .DATA_BITS  (8),
        .PARITY_BIT ("even"),
        .STOP_BITS  (2),
        .DIV_WIDTH  (16),
        .GUARD_BITS (2),
        .BREAK_BITS (12)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .bus             (u_if),
        .i_line          (line_i),
        .o_line_pull_low (pull_low)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (u_if.rx_valid) begin
            valid_cnt++;
            cap_data = u_if.rx_data;
            cap_perr = u_if.rx_parity_err;
            cap_ferr = u_if.rx_frame_err;
        end
        if (u_if.rx_break) break_cnt++;
        if (!u_if.rx_valid && (u_if.rx_parity_err || u_if.rx_frame_err)) flag_viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends one request and compares the pad drive to 14 expected line levels
    // (bit 0 = first bit-time), 8 clk each; tx_ready must return at exactly 112.
    task automatic tx_and_check(input string tag, input logic [7:0] d, input logic brk,
                                input logic [13:0] exp_line, input int chg_at);
        int bad_wave;
        int bad_ready;
        int rx0;
        rx0 = valid_cnt + break_cnt;
        bad_wave = 0;
        bad_ready = 0;
        u_if.tx_data    = d;
        u_if.tx_start   = 1'b1;
        u_if.send_break = brk;
        @(posedge clk);
        #1;
        u_if.tx_start   = 1'b0;
        u_if.send_break = 1'b0;
        for (int k = 0; k < 112; k++) begin
            @(negedge clk);
            if (pull_low !== ~exp_line[k/8]) bad_wave++;
            if (u_if.tx_ready !== 1'b0) bad_ready++;
            if (k == chg_at) u_if.baud_div = 16'd16;
        end
        @(posedge clk);
        #1;
        check({tag, "_wave_errs"}, bad_wave, 0);
        check({tag, "_busy_errs"}, bad_ready, 0);
        check({tag, "_ready_at_112"}, u_if.tx_ready, 1);
        check({tag, "_no_echo"}, valid_cnt + break_cnt, rx0);
        u_if.baud_div = 16'd8;
    endtask

    // Drives 12 line levels (bit 0 first), 8 clk each, then releases the line.
    task automatic send_ext(input logic [11:0] lv);
        for (int b = 0; b < 12; b++) begin
            ext_line = lv[b];
            cycles(8);
        end
        ext_line = 1'b1;
    endtask

    int v0;
    int b0;

    initial begin
        u_if.baud_div   = 16'd8;
        u_if.tx_data    = 8'h00;
        u_if.tx_start   = 1'b0;
        u_if.send_break = 1'b0;

        cycles(3);
        check("rst_pull_low", pull_low, 0);
        check("rst_rx_valid", u_if.rx_valid, 0);
        check("rst_rx_data", u_if.rx_data, 0);
        check("rst_rx_break", u_if.rx_break, 0);
        rst_n = 1'b1;
        cycles(3);
        check("rst_tx_ready", u_if.tx_ready, 1);

        // 0xA5 8E2: start, 1,0,1,0,0,1,0,1, parity 0, stop, stop, guard x2
        tx_and_check("tx_a5", 8'hA5, 1'b0, 14'b11110101001010, -1);
        cycles(4);

        // Good frame 0x3C, parity 0
        v0 = valid_cnt; b0 = break_cnt;
        send_ext(12'b110001111000);
        cycles(4);
        check("rx_ok_count", valid_cnt - v0, 1);
        check("rx_ok_data", cap_data, 8'h3C);
        check("rx_ok_perr", cap_perr, 0);
        check("rx_ok_ferr", cap_ferr, 0);
        check("rx_ok_break", break_cnt - b0, 0);

        // Same frame with parity 1
        v0 = valid_cnt;
        send_ext(12'b111001111000);
        cycles(4);
        check("rx_par_count", valid_cnt - v0, 1);
        check("rx_par_data", cap_data, 8'h3C);
        check("rx_par_perr", cap_perr, 1);
        check("rx_par_ferr", cap_ferr, 0);

        // Stop bit held low on 0x3C: frame error, then wait for high
        v0 = valid_cnt; b0 = break_cnt;
        send_ext(12'b000001111000);
        ext_line = 1'b0;
        cycles(10);
        check("rx_ferr_count", valid_cnt - v0, 1);
        check("rx_ferr_flag", cap_ferr, 1);
        check("rx_ferr_perr", cap_perr, 0);
        check("rx_ferr_data", cap_data, 8'h3C);
        check("rx_ferr_nobreak", break_cnt - b0, 0);
        check("rx_ferr_waiting", u_if.tx_ready, 0);
        ext_line = 1'b1;
        cycles(5);
        check("rx_ferr_released", u_if.tx_ready, 1);

        // 2-clk glitch: false start, idle again by clk 7 after the edge
        v0 = valid_cnt; b0 = break_cnt;
        ext_line = 1'b0;
        cycles(2);
        ext_line = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("glitch_ready_clk7", u_if.tx_ready, 1);
        cycles(100);
        check("glitch_no_valid", valid_cnt - v0, 0);
        check("glitch_no_break", break_cnt - b0, 0);

        // send_break and tx_start together: break wins, 96 low then 16 guard
        tx_and_check("tx_brk", 8'hFF, 1'b1, 14'b11000000000000, -1);
        cycles(4);

        // External 12-bit low: one break pulse, no rx_valid
        v0 = valid_cnt; b0 = break_cnt;
        send_ext(12'b000000000000);
        cycles(6);
        check("rx_brk_count", break_cnt - b0, 1);
        check("rx_brk_no_valid", valid_cnt - v0, 0);
        check("rx_brk_data_held", u_if.rx_data, 8'h3C);
        check("rx_brk_idle", u_if.tx_ready, 1);

        // baud_div changed to 16 at clk 20 of the frame: bits stay 8 clk
        tx_and_check("tx_div_chg", 8'h3C, 1'b0, 14'b11110001111000, 20);
        cycles(4);

        // Reset during data bit 3 of 0xA5 (line low there)
        v0 = valid_cnt;
        u_if.tx_data  = 8'hA5;
        u_if.tx_start = 1'b1;
        @(posedge clk);
        #1;
        u_if.tx_start = 1'b0;
        repeat (37) @(negedge clk);
        check("midrst_pull_before", pull_low, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_pull_now", pull_low, 0);
        check("midrst_ready_in_rst", u_if.tx_ready, 1);
        cycles(3);
        rst_n = 1'b1;
        cycles(2);
        check("midrst_ready_after", u_if.tx_ready, 1);
        cycles(120);
        check("midrst_pull_idle", pull_low, 0);
        check("midrst_no_valid", valid_cnt - v0, 0);

        check("flags_only_with_valid", flag_viol, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
